// File: rtl/uart_tx_fifo.sv
// UART transmitter with internal baud divider and a small valid/ready write FIFO.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [DATA_BITS-1:0]          data,
   input  logic                          valid,
   output logic                          ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned DIV_W   = $clog2(CLK_DIV + 1);
   localparam int unsigned CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W   = PTR_W + 1;

   // Reject illegal configurations at elaboration
   if (CLK_DIV < 1 || CLK_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
       STOP_BITS < 1 || STOP_BITS > 4 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter combination");
   end

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state;
   logic [DIV_W-1:0]     div;
   logic [CNT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [DATA_BITS-1:0] fifo_out;
   logic                 div_end;
   logic                 stop_end;
   logic                 push;
   logic                 pop;
`ifdef UART_TX_PARITY_EN
   logic                 par;
`endif

   assign ready    = (level != LVL_W'(FIFO_DEPTH));
   assign push     = valid && ready;
   assign div_end  = (div == DIV_W'(CLK_DIV - 1));
   assign stop_end = (state == STOP) && div_end && (bit_cnt == CNT_W'(STOP_BITS - 1));
   assign pop      = (level != '0) && ((state == IDLE) || stop_end);
   assign fifo_out = mem[rd_ptr];

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      level <= level + LVL_W'(1);
         else if (pop && !push) level <= level - LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= data;
   end

   // Frame sequencer; every bit is held for CLK_DIV clocks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         div     <= '0;
         bit_cnt <= '0;
         shift   <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift <= fifo_out;
`ifdef UART_TX_PARITY_EN
                  par   <= (^fifo_out) ^ 1'(PARITY_ODD);
`endif
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  div   <= '0;
               end
            end
            START: begin
               if (div_end) begin
                  div     <= '0;
                  tx      <= shift[0];
                  shift   <= {1'b0, shift[DATA_BITS-1:1]};
                  bit_cnt <= '0;
                  state   <= DATA;
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            DATA: begin
               if (div_end) begin
                  div <= '0;
                  if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                     tx      <= par;
                     state   <= PARITY;
`else
                     tx      <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                     tx      <= shift[0];
                     shift   <= {1'b0, shift[DATA_BITS-1:1]};
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (div_end) begin
                  div   <= '0;
                  tx    <= 1'b1;
                  state <= STOP;
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
`endif
            STOP: begin
               if (div_end) begin
                  div <= '0;
                  if (stop_end) begin
                     bit_cnt <= '0;
                     // Back-to-back frames: next start bit follows the last stop clock
                     if (pop) begin
                        shift <= fifo_out;
`ifdef UART_TX_PARITY_EN
                        par   <= (^fifo_out) ^ 1'(PARITY_ODD);
`endif
                        tx    <= 1'b0;
                        state <= START;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end else begin
                  div <= div + DIV_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
               div   <= '0;
            end
         endcase
      end
   end

endmodule
